bram_port_arbiter: RTL and testbench

//  Shares one BRAM port between two requesters: the TRS bus side (Z80 memory cycles at A15=1)
//  and the ESP/SPI side (peek/poke commands). Issues at most one access per clock.

---
 rtl/trs_io_pkg.sv | 24 ++
 rtl/bram_rd_tracker.sv | 60 ++++++
 rtl/bram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_bram_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trs_io_pkg.sv
// Shared types and constants for the TRS I/O BRAM access path.
// Contents:
//   BRAM_ADDR_W / BRAM_DATA_W  default BRAM port geometry
//   bram_owner_t               which requester a read result belongs to
//   rd_tag_t                   {valid, owner} tag carried alongside each read
//   RD_TAG_IDLE                empty tag used to flush the read pipeline
package trs_io_pkg;

  localparam int BRAM_ADDR_W = 16;
  localparam int BRAM_DATA_W = 8;

  typedef enum logic [0:0] {
    OWN_TRS = 1'b0,
    OWN_ESP = 1'b1
  } bram_owner_t;

  typedef struct packed {
    logic        valid;
    bram_owner_t owner;
  } rd_tag_t;

  localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, owner: OWN_TRS};

endpackage : trs_io_pkg

// File: rtl/bram_rd_tracker.sv
// Tracks reads in flight through the BRAM output-register pipeline.
// The tag of the read issued in cycle G is stage 0 (combinational, from the
// grant); registered stage k holds it in cycle G+k, k = 1..RD_LAT.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   issue_valid  a read is granted this cycle
//   issue_esp    owner of the granted access (1 = ESP, 0 = TRS)
//   mem_regce    BRAM output-register enable, cycle G+RD_LAT-1 of a read
//   cap_trs      capture mem_dout into TRS rdata at the end of this cycle
//   cap_esp      capture mem_dout into ESP rdata at the end of this cycle
//   busy         any read tag valid in any stage
module bram_rd_tracker
  import trs_io_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_valid,
  input  logic issue_esp,
  output logic mem_regce,
  output logic cap_trs,
  output logic cap_esp,
  output logic busy
);

  rd_tag_t tag_in_s;
  rd_tag_t tag_pipe_r [1:RD_LAT];
  logic    busy_s;

  assign tag_in_s = '{valid: issue_valid, owner: (issue_esp ? OWN_ESP : OWN_TRS)};

  // Shift tags one stage per clock; reset drops every read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= RD_LAT; k++) begin
        tag_pipe_r[k] <= RD_TAG_IDLE;
      end
    end else begin
      tag_pipe_r[1] <= tag_in_s;
      for (int k = 2; k <= RD_LAT; k++) begin
        tag_pipe_r[k] <= tag_pipe_r[k-1];
      end
    end
  end

  // OR of every valid tag, including the one being issued this cycle.
  always_comb begin
    busy_s = tag_in_s.valid;
    for (int k = 1; k <= RD_LAT; k++) begin
      busy_s = busy_s | tag_pipe_r[k].valid;
    end
  end

  assign mem_regce = !rst && tag_pipe_r[RD_LAT-1].valid;
  assign cap_trs   = tag_pipe_r[RD_LAT].valid && (tag_pipe_r[RD_LAT].owner == OWN_TRS);
  assign cap_esp   = tag_pipe_r[RD_LAT].valid && (tag_pipe_r[RD_LAT].owner == OWN_ESP);
  assign busy      = !rst && busy_s;

endmodule : bram_rd_tracker

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between the TRS bus side and the ESP/SPI side.
// One access per clock; TRS has fixed priority, and ESP is forced through
// after STARVE_MAX consecutive denied cycles. Read data returns to the owner
// of each read, in issue order, RD_LAT+1 cycles after the grant.
// Ports:
//   clk, rst                     system clock, synchronous active-high reset
//   trs_req/we/addr/wdata        TRS request (level, held until trs_ack)
//   trs_ack                      combinational grant
//   trs_rdata/trs_rvalid         registered read data and 1-cycle update pulse
//   esp_*                        same set for the ESP side
//   mem_en/we/addr/din           BRAM port A controls, driven in the grant cycle
//   mem_regce                    BRAM output-register clock enable
//   mem_dout                     BRAM read data
//   busy                         any read in flight
module bram_port_arbiter
  import trs_io_pkg::*;
#(
  parameter int ADDR_W     = BRAM_ADDR_W,
  parameter int DATA_W     = BRAM_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trs_req,
  input  logic              trs_we,
  input  logic [ADDR_W-1:0] trs_addr,
  input  logic [DATA_W-1:0] trs_wdata,
  output logic              trs_ack,
  output logic [DATA_W-1:0] trs_rdata,
  output logic              trs_rvalid,
  input  logic              esp_req,
  input  logic              esp_we,
  input  logic [ADDR_W-1:0] esp_addr,
  input  logic [DATA_W-1:0] esp_wdata,
  output logic              esp_ack,
  output logic [DATA_W-1:0] esp_rdata,
  output logic              esp_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_regce,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  wait_cnt_r;
  logic              force_esp_s;
  logic              grant_trs_s;
  logic              grant_esp_s;
  logic              rd_issue_s;
  logic              cap_trs_s;
  logic              cap_esp_s;
  logic [DATA_W-1:0] trs_rdata_r;
  logic [DATA_W-1:0] esp_rdata_r;
  logic              trs_rvalid_r;
  logic              esp_rvalid_r;

  // force_esp comes only from the registered counter, so the grant has no loop.
  assign force_esp_s = (wait_cnt_r == CNT_MAX);
  assign grant_trs_s = !rst && trs_req && !force_esp_s;
  assign grant_esp_s = !rst && esp_req && (!trs_req || force_esp_s);

  assign trs_ack = grant_trs_s;
  assign esp_ack = grant_esp_s;

  // Steer the winner onto the BRAM port; all zeros when nobody wins.
  always_comb begin
    if (grant_trs_s) begin
      mem_en   = 1'b1;
      mem_we   = trs_we;
      mem_addr = trs_addr;
      mem_din  = trs_wdata;
    end else if (grant_esp_s) begin
      mem_en   = 1'b1;
      mem_we   = esp_we;
      mem_addr = esp_addr;
      mem_din  = esp_wdata;
    end else begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
    end
  end

  assign rd_issue_s = (grant_trs_s && !trs_we) || (grant_esp_s && !esp_we);

  bram_rd_tracker #(
    .RD_LAT (RD_LAT)
  ) u_rd_tracker (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (rd_issue_s),
    .issue_esp   (grant_esp_s),
    .mem_regce   (mem_regce),
    .cap_trs     (cap_trs_s),
    .cap_esp     (cap_esp_s),
    .busy        (busy)
  );

  // Count consecutive cycles ESP is left waiting; any grant or release clears it.
  // It cannot pass CNT_MAX: at CNT_MAX a requesting ESP is always granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (esp_req && !grant_esp_s) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Capture read data for its owner and pulse that owner's rvalid one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      trs_rdata_r  <= '0;
      esp_rdata_r  <= '0;
      trs_rvalid_r <= 1'b0;
      esp_rvalid_r <= 1'b0;
    end else begin
      trs_rvalid_r <= cap_trs_s;
      esp_rvalid_r <= cap_esp_s;
      if (cap_trs_s) begin
        trs_rdata_r <= mem_dout;
      end
      if (cap_esp_s) begin
        esp_rdata_r <= mem_dout;
      end
    end
  end

  assign trs_rdata  = trs_rdata_r;
  assign esp_rdata  = esp_rdata_r;
  assign trs_rvalid = trs_rvalid_r;
  assign esp_rvalid = esp_rvalid_r;

endmodule : bram_port_arbiter

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter (RD_LAT=2, STARVE_MAX=8) with a
// behavioural BRAM (registered core output plus output register) and a
// scoreboard of expected read results {owner, data, return cycle}.
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        trs_req, trs_we, trs_ack, trs_rvalid;
  logic [15:0] trs_addr;
  logic [7:0]  trs_wdata, trs_rdata;
  logic        esp_req, esp_we, esp_ack, esp_rvalid;
  logic [15:0] esp_addr;
  logic [7:0]  esp_wdata, esp_rdata;
  logic        mem_en, mem_we, mem_regce, busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;

  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  bram [0:65535];
  logic [7:0]  bram_q;
  logic [7:0]  shadow [0:65535];

  typedef struct {
    logic       own;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  logic [7:0] exp_trs_rd = 8'h00;
  logic [7:0] exp_esp_rd = 8'h00;

  logic [15:0] pl_addrs [0:4] = '{16'h8000, 16'h9000, 16'h9001, 16'h9002, 16'h9003};
  logic [7:0]  pl_datas [0:4] = '{8'h5A, 8'hA0, 8'hA1, 8'hA2, 8'hA3};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: en -> core register, regce -> output register.
  always @(posedge clk) begin
    if (pl_en) bram[pl_addr] <= pl_data;
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_din;
      else        bram_q <= bram[mem_addr];
    end
    if (mem_regce) mem_dout <= bram_q;
  end

  bram_port_arbiter #(
    .ADDR_W(16), .DATA_W(8), .RD_LAT(2), .STARVE_MAX(8)
  ) dut (
    .clk(clk), .rst(rst),
    .trs_req(trs_req), .trs_we(trs_we), .trs_addr(trs_addr), .trs_wdata(trs_wdata),
    .trs_ack(trs_ack), .trs_rdata(trs_rdata), .trs_rvalid(trs_rvalid),
    .esp_req(esp_req), .esp_we(esp_we), .esp_addr(esp_addr), .esp_wdata(esp_wdata),
    .esp_ack(esp_ack), .esp_rdata(esp_rdata), .esp_rvalid(esp_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_regce(mem_regce), .mem_dout(mem_dout), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample on the falling edge: port mirror, scoreboard pop on rvalid, push on grants.
  task automatic sample();
    exp_t        e;
    logic [25:0] port_exp;
    @(negedge clk);
    if (pl_en) shadow[pl_addr] = pl_data;
    if (rst) begin
      sb.delete();
      exp_trs_rd = 8'h00;
      exp_esp_rd = 8'h00;
      chk("rst_gate", {2'b00, trs_ack, esp_ack, mem_en, mem_we, mem_addr, mem_din, mem_regce, busy}, 32'd0);
    end else begin
      chk("ack_excl", {31'd0, trs_ack & esp_ack}, 32'd0);
      if (trs_ack)      port_exp = {1'b1, trs_we, trs_addr, trs_wdata};
      else if (esp_ack) port_exp = {1'b1, esp_we, esp_addr, esp_wdata};
      else              port_exp = 26'd0;
      chk("mem_port", {6'd0, mem_en, mem_we, mem_addr, mem_din}, {6'd0, port_exp});
      if (trs_rvalid || esp_rvalid) begin
        if (sb.size() == 0) begin
          chk("rvalid_unexpected", {30'd0, trs_rvalid, esp_rvalid}, 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.own) exp_esp_rd = e.data;
          else       exp_trs_rd = e.data;
          chk("rv_route", {30'd0, trs_rvalid, esp_rvalid}, e.own ? 32'd1 : 32'd2);
          chk("rv_cycle", 32'(cyc), 32'(e.due));
          chk("rv_rdata", {16'd0, trs_rdata, esp_rdata}, {16'd0, exp_trs_rd, exp_esp_rd});
        end
      end
      if (trs_req && trs_ack) begin
        if (trs_we) shadow[trs_addr] = trs_wdata;
        else        sb.push_back('{own: 1'b0, data: shadow[trs_addr], due: cyc + 3});
      end
      if (esp_req && esp_ack) begin
        if (esp_we) shadow[esp_addr] = esp_wdata;
        else        sb.push_back('{own: 1'b1, data: shadow[esp_addr], due: cyc + 3});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    trs_req = 1'b0; trs_we = 1'b0; trs_addr = 16'h0000; trs_wdata = 8'h00;
    esp_req = 1'b0; esp_we = 1'b0; esp_addr = 16'h0000; esp_wdata = 8'h00;
    pl_en = 1'b0; pl_addr = 16'h0000; pl_data = 8'h00;

    // Reset: preload BRAM, and requests must stay ungranted.
    for (int i = 0; i < 5; i++) begin
      pl_en = 1'b1; pl_addr = pl_addrs[i]; pl_data = pl_datas[i];
      sample();
      step();
    end
    pl_en = 1'b0;
    trs_req = 1'b1; trs_addr = 16'h8000; esp_req = 1'b1;
    sample();
    chk("rst_trs_ack", {31'd0, trs_ack}, 32'd0);
    chk("rst_esp_ack", {31'd0, esp_ack}, 32'd0);
    chk("rst_rvalid", {30'd0, trs_rvalid, esp_rvalid}, 32'd0);
    chk("rst_rdata", {16'd0, trs_rdata, esp_rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0; trs_req = 1'b0; esp_req = 1'b0;
    idle(2);

    // 1: single TRS read of 0x8000.
    trs_req = 1'b1; trs_we = 1'b0; trs_addr = 16'h8000;
    sample();
    chk("t1_ack", {31'd0, trs_ack}, 32'd1);
    chk("t1_en", {31'd0, mem_en}, 32'd1);
    chk("t1_regce_g", {31'd0, mem_regce}, 32'd0);
    step();
    trs_req = 1'b0;
    sample();
    chk("t1_regce_g1", {31'd0, mem_regce}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    step();
    sample();
    chk("t1_regce_g2", {31'd0, mem_regce}, 32'd0);
    chk("t1_rvalid_g2", {31'd0, trs_rvalid}, 32'd0);
    step();
    sample();
    chk("t1_rvalid_g3", {30'd0, trs_rvalid, esp_rvalid}, 32'd2);
    chk("t1_rdata", {24'd0, trs_rdata}, 32'h5A);
    step();
    sample();
    chk("t1_rvalid_g4", {31'd0, trs_rvalid}, 32'd0);
    chk("t1_busy_done", {31'd0, busy}, 32'd0);
    step();
    idle(2);

    // 2: TRS write 0x8001=0x11 collides with ESP read of 0x8001.
    trs_req = 1'b1; trs_we = 1'b1; trs_addr = 16'h8001; trs_wdata = 8'h11;
    esp_req = 1'b1; esp_we = 1'b0; esp_addr = 16'h8001;
    sample();
    chk("t2_trs_ack", {30'd0, trs_ack, esp_ack}, 32'd2);
    chk("t2_we", {31'd0, mem_we}, 32'd1);
    step();
    trs_req = 1'b0; trs_we = 1'b0;
    sample();
    chk("t2_esp_ack", {30'd0, trs_ack, esp_ack}, 32'd1);
    step();
    esp_req = 1'b0;
    idle(2);
    sample();
    chk("t2_esp_rvalid", {30'd0, trs_rvalid, esp_rvalid}, 32'd1);
    chk("t2_esp_rdata", {24'd0, esp_rdata}, 32'h11);
    step();
    idle(2);

    // 3: TRS holds req; ESP wins only after 8 denied cycles.
    trs_req = 1'b1; trs_addr = 16'h8000;
    sample();
    step();
    esp_req = 1'b1; esp_addr = 16'h8001;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("t3_denied", {30'd0, trs_ack, esp_ack}, 32'd2);
      step();
    end
    sample();
    chk("t3_forced", {30'd0, trs_ack, esp_ack}, 32'd1);
    step();
    esp_req = 1'b0;
    sample();
    chk("t3_trs_resume", {30'd0, trs_ack, esp_ack}, 32'd2);
    step();
    trs_req = 1'b0;
    idle(5);

    // 4: interleaved reads T,E,T,E at 0x9000..0x9003.
    for (int i = 0; i < 7; i++) begin
      trs_req = (i == 0 || i == 2);
      esp_req = (i == 1 || i == 3);
      trs_addr = 16'h9000 + 16'(i);
      esp_addr = 16'h9000 + 16'(i);
      sample();
      chk("t4_busy", {31'd0, busy}, (i <= 5) ? 32'd1 : 32'd0);
      chk("t4_rvalid", {30'd0, trs_rvalid, esp_rvalid},
          (i == 3 || i == 5) ? 32'd2 : ((i == 4 || i == 6) ? 32'd1 : 32'd0));
      if (i >= 3) begin
        chk("t4_rdata", {24'd0, (i == 3 || i == 5) ? trs_rdata : esp_rdata}, {24'd0, 8'hA0 + 8'(i - 3)});
      end
      step();
    end
    trs_req = 1'b0; esp_req = 1'b0;
    idle(2);

    // 5: reset one cycle after a TRS read is granted.
    trs_req = 1'b1; trs_addr = 16'h9000;
    sample();
    chk("t5_ack", {31'd0, trs_ack}, 32'd1);
    step();
    trs_req = 1'b0; rst = 1'b1; esp_req = 1'b1; esp_addr = 16'h9001;
    sample();
    chk("t5_rst_ack", {30'd0, trs_ack, esp_ack}, 32'd0);
    step();
    rst = 1'b0;
    sample();
    chk("t5_busy_after", {31'd0, mem_en & esp_ack}, 32'd1);
    chk("t5_no_rvalid_g2", {31'd0, trs_rvalid}, 32'd0);
    step();
    esp_req = 1'b0; trs_req = 1'b1; trs_addr = 16'h9002;
    sample();
    chk("t5_new_ack", {31'd0, trs_ack}, 32'd1);
    chk("t5_no_rvalid_g3", {31'd0, trs_rvalid}, 32'd0);
    step();
    trs_req = 1'b0;
    sample();
    chk("t5_no_rvalid_g4", {31'd0, trs_rvalid}, 32'd0);
    step();
    sample();
    chk("t5_esp_rvalid_g5", {30'd0, trs_rvalid, esp_rvalid}, 32'd1);
    step();
    sample();
    chk("t5_rvalid_g6", {30'd0, trs_rvalid, esp_rvalid}, 32'd2);
    chk("t5_rdata", {24'd0, trs_rdata}, 32'hA2);
    step();
    idle(2);
    sample();
    chk("t5_busy_idle", {31'd0, busy}, 32'd0);
    step();

    // 6: ESP denied 5 cycles, drops 1, reasserts; counter restarts from 0.
    trs_req = 1'b1; trs_addr = 16'h8000;
    esp_req = 1'b1; esp_addr = 16'h8001;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("t6_pre_denied", {31'd0, esp_ack}, 32'd0);
      step();
    end
    esp_req = 1'b0;
    sample();
    chk("t6_drop_trs", {31'd0, trs_ack}, 32'd1);
    step();
    esp_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("t6_denied", {31'd0, esp_ack}, 32'd0);
      step();
    end
    sample();
    chk("t6_forced", {30'd0, trs_ack, esp_ack}, 32'd1);
    step();
    trs_req = 1'b0; esp_req = 1'b0;
    idle(6);

    sample();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_bram_port_arbiter
